// File: rtl/leb128_decoder_if.sv
// leb128_decoder_if -- byte-in / result-out bundle for the LEB128 immediate decoder.
//   in_valid/in_ready/in_data : one encoded byte per beat (bit 7 = continuation)
//   mode_signed/mode_64       : form and target width, sampled with the first byte
//   out_valid/out_ready       : result handshake
//   out_value/out_len/out_error : decoded value, encoded length (1..10), malformed flag
// slave  = decoder side, master = fetch/core side.
`timescale 1ns/1ps
interface leb128_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mode_signed;
  logic        mode_64;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;

  modport slave (
    input  in_valid, in_data, mode_signed, mode_64, out_ready,
    output in_ready, out_valid, out_value, out_len, out_error
  );

  modport master (
    output in_valid, in_data, mode_signed, mode_64, out_ready,
    input  in_ready, out_valid, out_value, out_len, out_error
  );
endinterface

// File: rtl/leb128_decoder.sv
// leb128_decoder -- streaming uLEB128/sLEB128 immediate decoder, 32/64-bit targets.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : leb128_decoder_if.slave (byte input stream + result output)
// Build option:
//   LEB128_STRICT_EN : when defined, the unused high bits of the final
//   (MAXB-th) byte are checked and a violation is reported as out_error.
//   Without it those bits are silently truncated.
`timescale 1ns/1ps
module leb128_decoder #(
  parameter int VALUE_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  leb128_decoder_if.slave bus
);

  if (VALUE_W != 64) begin : g_bad_value_w
    $error("leb128_decoder: VALUE_W must be 64");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q;
  logic [VALUE_W-1:0] acc_q;
  logic [3:0]         cnt_q;
  logic               sgn_q, m64_q;
  logic               out_valid_q, out_error_q;
  logic [VALUE_W-1:0] out_value_q;
  logic [3:0]         out_len_q;

  // next-state candidates for the byte being presented this cycle
  logic               idle;
  logic               sgn_d, m64_d;
  logic [3:0]         n, len_d, maxb;
  logic [6:0]         shamt, s;
  logic [VALUE_W-1:0] base, acc_d, fmt, mask, val_d;
  logic               at_max, too_long, strict_bad, err_d, done_d;

  assign idle = (state_q == IDLE);

  always_comb begin
    // first byte takes the mode pins and starts from an empty accumulator
    sgn_d  = idle ? bus.mode_signed : sgn_q;
    m64_d  = idle ? bus.mode_64     : m64_q;
    n      = idle ? 4'd0 : cnt_q;
    base   = idle ? '0   : acc_q;
    shamt  = {3'b000, n} * 7'd7;
    // bits pushed past bit 63 fall off the top of the shift
    acc_d  = base | ({57'b0, bus.in_data[6:0]} << shamt);
    len_d  = n + 4'd1;
    maxb   = m64_d ? 4'd10 : 4'd5;
    at_max = (len_d == maxb);
    too_long = bus.in_data[7] && at_max;
    done_d = !bus.in_data[7] || at_max;

    strict_bad = 1'b0;
`ifdef LEB128_STRICT_EN
    if (at_max && !bus.in_data[7]) begin
      case ({sgn_d, m64_d})
        2'b00: strict_bad = (bus.in_data[6:4] != 3'b000);
        2'b10: strict_bad = !((bus.in_data[6:3] == 4'h0) || (bus.in_data[6:3] == 4'hF));
        2'b01: strict_bad = (bus.in_data[6:1] != 6'h00);
        default: strict_bad = !((bus.in_data[6:0] == 7'h00) || (bus.in_data[6:0] == 7'h7F));
      endcase
    end
`endif

    // signed: extend from the last payload bit while it lies inside 64 bits
    s    = {3'b000, len_d} * 7'd7;
    fmt  = acc_d;
    mask = '1;
    if (sgn_d && (s < 7'd64)) begin
      mask = '1 << s;
      if (acc_d[6'(s - 7'd1)]) fmt = acc_d | mask;
      else                     fmt = acc_d & ~mask;
    end
    // 32-bit targets: the upper word always follows bit 31 (or is zero)
    if (!m64_d) fmt[63:32] = sgn_d ? {32{fmt[31]}} : 32'h0;

    err_d = too_long || strict_bad;
    val_d = err_d ? '0 : fmt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      m64_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_len_q   <= '0;
      out_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (bus.in_valid) begin
            acc_q <= acc_d;
            cnt_q <= len_d;
            sgn_q <= sgn_d;
            m64_q <= m64_d;
            if (done_d) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_value_q <= val_d;
              out_len_q   <= len_d;
              out_error_q <= err_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          // results are held until taken; the accept cycle takes no byte
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_error = out_error_q;

endmodule

// File: tb/tb_leb128_decoder.sv
`timescale 1ns/1ps
module tb_leb128_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  leb128_decoder_if bus();

  leb128_decoder #(.VALUE_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // present one byte at the negedge, it is taken at the following posedge
  task automatic send(input logic [7:0] b, input logic sgn, input logic m64);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_data     = b;
    bus.mode_signed = sgn;
    bus.mode_64     = m64;
    chk("in_ready_before_byte", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [63:0] v, input logic [3:0] len,
                           input logic err);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_value"}, bus.out_value, v);
    chk({tag, "_len"},   64'(bus.out_len), 64'(len));
    chk({tag, "_err"},   64'(bus.out_error), 64'(err));
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("take_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("take_ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.mode_signed = 1'b0;
    bus.mode_64     = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_value", bus.out_value, 64'd0);
    chk("rst_len",   64'(bus.out_len), 64'd0);
    chk("rst_err",   64'(bus.out_error), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // u32 E5 8E 26 -> 624485
    send(8'hE5, 1'b0, 1'b0);
    send(8'h8E, 1'b0, 1'b0);
    chk("u32_no_early_valid", 64'(bus.out_valid), 64'd0);
    send(8'h26, 1'b0, 1'b0);
    check_res("u32", 64'h0000_0000_0009_8765, 4'd3, 1'b0);
    take();

    // s32 7F -> -1
    send(8'h7F, 1'b1, 1'b0);
    check_res("s32_m1", 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
    take();

    // s64 C0 BB 78 -> -123456
    send(8'hC0, 1'b1, 1'b1);
    send(8'hBB, 1'b1, 1'b1);
    send(8'h78, 1'b1, 1'b1);
    check_res("s64", 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
    take();

    // mode is latched on the first byte: FF 7F signed stays -1 after mode pin drops
    send(8'hFF, 1'b1, 1'b0);
    send(8'h7F, 1'b0, 1'b1);
    check_res("latch", 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 1'b0);
    take();

    // u32 five continuation bytes -> length error, 6th byte refused
    for (int i = 0; i < 5; i++) send(8'h80, 1'b0, 1'b0);
    check_res("toolong", 64'd0, 4'd5, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    chk("toolong_6th_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_res("toolong_held", 64'd0, 4'd5, 1'b1);
    take();

    // u64 ten bytes, last payload bit lands on bit 63
    for (int i = 0; i < 9; i++) send(8'h80, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b1);
    check_res("u64_max", 64'h8000_0000_0000_0000, 4'd10, 1'b0);
    take();

    // u32 FF FF FF FF 1F: unused bits of the last byte
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b0, 1'b0);
    send(8'h1F, 1'b0, 1'b0);
`ifdef LEB128_STRICT_EN
    check_res("u32_top", 64'd0, 4'd5, 1'b1);
`else
    check_res("u32_top", 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0);
`endif
    take();

    // backpressure: result held while out_ready is low
    send(8'h2A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h05;
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_value", bus.out_value, 64'h2A);
    end
    bus.in_valid = 1'b0;
    check_res("bp", 64'h2A, 4'd1, 1'b0);
    take();

    // reset mid-sequence discards the partial value
    send(8'h80, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    send(8'h05, 1'b0, 1'b0);
    check_res("midrst", 64'd5, 4'd1, 1'b0);
    take();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Streaming LEB128 immediate decoder between the instruction-fetch byte path (genrom data, one byte per beat) and the core's decode/execute stage.
- Accepts the encoded bytes of one `i32.const` / `i64.const` / index immediate and returns the decoded 64-bit value, its encoded length (so the core can advance the PC) and an error flag the core converts into a trap.
- Supports unsigned and signed forms in 32-bit and 64-bit widths.

Parameters:
- VALUE_W, 64: width of `out_value`. Fixed at 64; any other value is a build-time `$error`.

Ports:
- `clk` — input, 1 — clock; all state on rising edge.
- `reset` — input, 1 — asynchronous, active-low reset (asserted at 0).
- `in_valid` — input, 1 — `in_data` holds an encoded byte.
- `in_ready` — output, 1 — decoder accepts a byte this cycle.
- `in_data` — input, 8 — encoded byte; bit 7 is the continuation bit.
- `mode_signed` — input, 1 — sampled with the first byte: 1 = sLEB128, 0 = uLEB128.
- `mode_64` — input, 1 — sampled with the first byte: 1 = 64-bit target, 0 = 32-bit target.
- `out_valid` — output, 1 — decoded result held.
- `out_ready` — input, 1 — consumer takes the result.
- `out_value` — output, 64 — decoded value.
- `out_len` — output, 4 — number of bytes consumed, 1..10.
- `out_error` — output, 1 — malformed encoding.

Behaviour:

States:
- IDLE: no byte consumed yet.
- ACCUM: at least one byte consumed, terminator not yet seen.
- DONE: result held.

Reset:
- State = IDLE; `out_valid` = 0; `out_value` = 0; `out_len` = 0; `out_error` = 0.
- Internal accumulator, shift count, byte count and latched mode bits are cleared.
- Reset asserted mid-operation discards the partial value; no output is produced for it.

Input handshake:
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
- A byte is accepted on a cycle with `in_valid && in_ready`.

Byte acceptance:
- In IDLE, `mode_signed` and `mode_64` are latched.
- The accumulator takes `acc |= in_data[6:0] << (7*n)`, where n is the 0-based byte index.
- Bits shifted beyond bit 63 are dropped.

Limits and transitions:
- MAXB = 5 when `mode_64` = 0, MAXB = 10 when `mode_64` = 1.
- Byte with bit 7 = 0 → DONE.
- Byte with bit 7 = 1 and n+1 < MAXB → ACCUM.
- Byte with bit 7 = 1 and n+1 == MAXB → DONE with `out_error` = 1 (encoding too long).
  - Any remaining bytes are not consumed; the core traps.

Result latency:
- `out_valid` rises the cycle after the terminating byte is accepted.
- `out_value`, `out_len` and `out_error` are registered and stable while `out_valid` = 1.

Result formatting (applied when entering DONE):
- Signed, final shift s = 7*(n+1) < 64: sign-extend from bit s-1.
- 32-bit mode, signed: `out_value[63:32]` = copy of bit 31.
- 32-bit mode, unsigned: `out_value[63:32]` = 0.
- On error, `out_value` = 0.
- `out_len` = n+1.

Output handshake:
- In DONE, `out_valid && out_ready` → IDLE on the next edge and `out_valid` drops.
- No byte is accepted in that same cycle, so the minimum spacing between results is one idle cycle.

Boundary conditions:
- `in_valid` low mid-sequence: the decoder stalls in ACCUM indefinitely; there is no timeout.
- `out_ready` held low: DONE is held and input is backpressured.

Optional Feature:
- Macro: `LEB128_STRICT_EN`.
- Defined — checks applied to the final (MAXB-th) byte; a violation gives DONE with `out_error` = 1 and `out_value` = 0:
  - u32: bits 6:4 must be 0.
  - s32: bits 6:3 must be all equal.
  - u64: bits 6:1 must be 0.
  - s64: bits 6:0 must be 0x00 or 0x7F.
- Undefined: no check is made on unused bits; they are truncated per the width rules and no error is raised. The length-limit error always applies, with or without the macro.

Test Plan:
- u32, bytes E5 8E 26 → `out_value` = 0x0000_0000_0009_8765 (624485), `out_len` = 3, `out_error` = 0; `out_valid` is asserted 1 cycle after the 3rd byte.
- s32, byte 7F → `out_value` = 0xFFFF_FFFF_FFFF_FFFF (-1), `out_len` = 1; s64, bytes C0 BB 78 → 0xFFFF_FFFF_FFFE_1DC0 (-123456), `out_len` = 3.
- u32, bytes 80 80 80 80 80 → `out_error` = 1, `out_len` = 5, `out_value` = 0; a 6th byte presented is not accepted (`in_ready` = 0).
- u32, bytes FF FF FF FF 1F → with `LEB128_STRICT_EN`: `out_error` = 1; without it: `out_value` = 0x0000_0000_FFFF_FFFF, `out_error` = 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles after result 0x2A (byte 2A) → `out_valid` held, `in_ready` = 0, value stable; `out_ready` = 1 → IDLE next cycle.
- Reset mid-sequence: send 80 80, assert `reset` = 0 for 1 cycle, then send 05 → `out_value` = 5, `out_len` = 1.
